lfsr_period_meter: RTL and testbench

LFSR_PERIOD_METER -- requirements
Module: lfsr_period_meter

---
 rtl/lfsr_period_meter.sv | 89 ++++++++
 tb/tb_lfsr_period_meter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_period_meter.sv
// Measures the period of an upstream LFSR: counts steps from a captured reference
// value until the same value reappears, saturating at all-ones when it never does.
module lfsr_period_meter #(
  parameter int LFSR_BITS  = 5,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  step,
  input  logic [LFSR_BITS-1:0]  value,
  output logic [COUNT_BITS-1:0] period,
  output logic                  valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNT_BITS-1:0] CNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  state_t                 state, state_next;
  logic [COUNT_BITS-1:0]  count, count_next, count_inc;
  logic [LFSR_BITS-1:0]   ref_val, ref_next;
  logic [COUNT_BITS-1:0]  period_next;
  logic                   valid_next, overflow_next;

  // valid is a level, not a handshake: it stays high with period until the next
  // start or reset, and nothing downstream acknowledges it.
  assign busy      = (state == S_MEASURE);
  assign state_dbg = state;
  assign count_inc = count + CNT_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      count    <= '0;
      ref_val  <= '0;
      period   <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      ref_val  <= ref_next;
      period   <= period_next;
      valid    <= valid_next;
      overflow <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    ref_next      = ref_val;
    period_next   = period;
    valid_next    = valid;
    overflow_next = overflow;

    if (start) begin
      // A coincident step is deliberately dropped: the value seen now is the reference.
      state_next    = S_MEASURE;
      count_next    = '0;
      ref_next      = value;
      valid_next    = 1'b0;
      overflow_next = 1'b0;
    end else if (state == S_MEASURE && step) begin
      count_next = count_inc;
      if (value == ref_val) begin
        state_next    = S_DONE;
        period_next   = count_inc;
        valid_next    = 1'b1;
        overflow_next = 1'b0;
      end else if (count_inc == CNT_MAX) begin
        state_next    = S_DONE;
        period_next   = CNT_MAX;
        valid_next    = 1'b1;
        overflow_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_period_meter.sv
// Bench for lfsr_period_meter: a vector table, directed LFSR runs and random
// stimulus, all checked against a step-counting reference model for 8- and 4-bit counters.
module tb_lfsr_period_meter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, step;
  logic [4:0] value;

  logic [7:0] period8;
  logic       valid8, busy8, ovf8;
  logic [1:0] st8;
  logic [3:0] period4;
  logic       valid4, busy4, ovf4;
  logic [1:0] st4;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // clock / reset
  always #5 clk = ~clk;

  lfsr_period_meter #(.LFSR_BITS(5), .COUNT_BITS(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .step(step), .value(value),
    .period(period8), .valid(valid8), .busy(busy8), .overflow(ovf8), .state_dbg(st8));

  lfsr_period_meter #(.LFSR_BITS(5), .COUNT_BITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .step(step), .value(value),
    .period(period4), .valid(valid4), .busy(busy4), .overflow(ovf4), .state_dbg(st4));

  // reference model: phase 0 idle, 1 measuring, 2 result held
  int         m_phase[2];
  int         m_steps[2];
  int         m_max[2] = '{255, 15};
  int         m_period[2];
  bit         m_valid[2], m_ovf[2];
  logic [4:0] m_ref[2];

  // scoreboard of results expected from the 8-bit instance
  logic [7:0] exp_q[$];
  logic       prev_valid8 = 1'b0;

  logic [4:0] lfsr;

  function automatic logic [4:0] lfsr_next(input logic [4:0] v);
    return (v >> 1) ^ (v[0] ? 5'h14 : 5'h00);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_steps[k] = 0; m_period[k] = 0;
      m_valid[k] = 1'b0; m_ovf[k] = 1'b0; m_ref[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (start) begin
        m_phase[k] = 1; m_steps[k] = 0; m_ref[k] = value;
        m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
      end else if (m_phase[k] == 1 && step) begin
        m_steps[k]++;
        if (value == m_ref[k]) begin
          m_phase[k] = 2; m_period[k] = m_steps[k]; m_valid[k] = 1'b1; m_ovf[k] = 1'b0;
          if (k == 0) exp_q.push_back(8'(m_steps[k]));
        end else if (m_steps[k] == m_max[k]) begin
          m_phase[k] = 2; m_period[k] = m_max[k]; m_valid[k] = 1'b1; m_ovf[k] = 1'b1;
          if (k == 0) exp_q.push_back(8'(m_max[k]));
        end
      end
    end
  endtask

  task automatic check_model();
    chk("period8", period8, m_period[0]);
    chk("valid8", valid8, m_valid[0]);
    chk("busy8", busy8, m_phase[0] == 1);
    chk("ovf8", ovf8, m_ovf[0]);
    chk("state8", st8, m_phase[0]);
    chk("period4", period4, m_period[1]);
    chk("valid4", valid4, m_valid[1]);
    chk("busy4", busy4, m_phase[1] == 1);
    chk("ovf4", ovf4, m_ovf[1]);
    chk("state4", st4, m_phase[1]);
  endtask

  // one clock: model sees the same inputs the DUTs sample, outputs checked 1ns later
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_model();
    if (valid8 && !prev_valid8) begin
      if (exp_q.size() == 0) chk("sb_unexpected_result", 1, 0);
      else chk("sb_period8", period8, exp_q.pop_front());
    end
    prev_valid8 = valid8;
  endtask

  task automatic drive(input logic s, input logic st, input logic [4:0] v);
    start = s; step = st; value = v;
  endtask

  task automatic run_lfsr(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap - 1; g++) begin
        drive(1'b0, 1'b0, lfsr);
        tick();
      end
      lfsr = lfsr_next(lfsr);
      drive(1'b0, 1'b1, lfsr);
      tick();
    end
    drive(1'b0, 1'b0, lfsr);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    chk("rst_period8", period8, 0);
    chk("rst_valid8", valid8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_ovf4", ovf4, 0);
    chk("rst_valid4", valid4, 0);
    #1 reset_n = 1'b1;
    prev_valid8 = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       step;
    logic [4:0] value;
    logic [7:0] period;
    logic       valid;
    logic       busy;
    logic       ovf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // steps in IDLE, then period-1 lock-up case, DONE hold, restart with a coincident step
    tbl[0]  = '{1'b0, 1'b1, 5'd3, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5'd0, 8'd1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 5'd7, 8'd1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 5'd3, 8'd1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'd9, 8'd1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 5'd1, 8'd1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 5'd3, 8'd2, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 5'd3, 8'd2, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 5'd2, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 5'd2, 8'd1, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_period8", period8, 0);
    chk("reset_valid8", valid8, 0);
    chk("reset_busy8", busy8, 0);
    chk("reset_ovf8", ovf8, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].start, tbl[i].step, tbl[i].value);
      tick();
      chk($sformatf("tbl%0d_period", i), period8, tbl[i].period);
      chk($sformatf("tbl%0d_valid", i), valid8, tbl[i].valid);
      chk($sformatf("tbl%0d_busy", i), busy8, tbl[i].busy);
      chk($sformatf("tbl%0d_ovf", i), ovf8, tbl[i].ovf);
    end

    // maximal 5-bit sequence, step every 3 cycles
    lfsr = 5'h01;
    drive(1'b1, 1'b0, lfsr);
    tick();
    run_lfsr(15, 3);
    chk("sat4_period", period4, 15);
    chk("sat4_ovf", ovf4, 1);
    chk("sat4_valid", valid4, 1);
    chk("run31_busy_mid", busy8, 1);
    run_lfsr(16, 3);
    chk("run31_period", period8, 31);
    chk("run31_valid", valid8, 1);
    chk("run31_ovf", ovf8, 0);
    chk("run31_busy", busy8, 0);

    // restart mid-measurement with a coincident step
    lfsr = 5'h01;
    drive(1'b1, 1'b0, lfsr);
    tick();
    run_lfsr(10, 2);
    lfsr = 5'h09;
    drive(1'b1, 1'b1, lfsr);
    tick();
    chk("restart_busy", busy8, 1);
    chk("restart_valid", valid8, 0);
    run_lfsr(30, 2);
    chk("restart_valid_early", valid8, 0);
    run_lfsr(1, 2);
    chk("restart_period", period8, 31);
    chk("restart_valid_end", valid8, 1);

    // asynchronous reset mid-measurement, then steps must yield no result
    lfsr = 5'h01;
    drive(1'b1, 1'b0, lfsr);
    tick();
    run_lfsr(5, 2);
    reset_pulse();
    run_lfsr(40, 2);
    chk("post_rst_valid", valid8, 0);
    chk("post_rst_busy", busy8, 0);

    // random traffic
    lfsr = 5'h01;
    for (int i = 0; i < 1500; i++) begin
      logic s, st;
      s  = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 1) == 1);
      if (st || s) begin
        if ($urandom_range(0, 9) < 8) lfsr = lfsr_next(lfsr);
        else lfsr = 5'($urandom_range(0, 31));
      end
      drive(s, st, lfsr);
      tick();
      if ($urandom_range(0, 299) == 0) reset_pulse();
    end

    drive(1'b0, 1'b0, lfsr);
    tick();
    chk("sb_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
